// File: rtl/miriscv_mdu_seq_if.sv
// miriscv_mdu_seq_if: bundles the issue, flush, MDU and writeback signals of
// the M-extension sequencer.
//
// Handshakes: an issue transfer happens on a rising edge where issue_valid_i
// and issue_ready_o are both 1. A writeback transfer happens on a rising edge
// where wb_valid_o and wb_ready_i are both 1. Once wb_valid_o is raised from
// the DONE state, it stays high with wb_rd_o/wb_data_o stable until the
// transfer happens or a flush/reset drops it. The MDU result is taken on any
// edge where mdu_req_o=1 and mdu_stall_req_i=0.
interface miriscv_mdu_seq_if;
   // issue side
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic [2:0]  issue_op_i;
   logic [31:0] issue_a_i;
   logic [31:0] issue_b_i;
   logic [4:0]  issue_rd_i;
   logic        flush_i;
   // MDU side
   logic        mdu_req_o;
   logic [2:0]  mdu_op_o;
   logic [31:0] mdu_port_a_o;
   logic [31:0] mdu_port_b_o;
   logic        mdu_kill_o;
   logic        mdu_stall_req_i;
   logic [31:0] mdu_result_i;
   // writeback side
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;

   // sequencer view
   modport slave (
      input  issue_valid_i, issue_op_i, issue_a_i, issue_b_i, issue_rd_i, flush_i,
      input  mdu_stall_req_i, mdu_result_i, wb_ready_i,
      output issue_ready_o, mdu_req_o, mdu_op_o, mdu_port_a_o, mdu_port_b_o,
      output mdu_kill_o, wb_valid_o, wb_rd_o, wb_data_o
   );

   // environment view (decode stage, MDU and writeback driver)
   modport master (
      output issue_valid_i, issue_op_i, issue_a_i, issue_b_i, issue_rd_i, flush_i,
      output mdu_stall_req_i, mdu_result_i, wb_ready_i,
      input  issue_ready_o, mdu_req_o, mdu_op_o, mdu_port_a_o, mdu_port_b_o,
      input  mdu_kill_o, wb_valid_o, wb_rd_o, wb_data_o
   );
endinterface

// File: rtl/miriscv_mdu_seq.sv
// miriscv_mdu_seq: sequences one M-extension operation at a time from the
// decode stage to miriscv_mdu and returns the result over a writeback
// handshake, counting retired operations.
//
// Optional feature: define MIRISCV_MDU_SEQ_BYPASS_EN to present the MDU
// result on writeback in the completion cycle itself; if writeback accepts it
// there, the FSM returns straight to IDLE. Without the macro the result is
// always registered first and offered from DONE.
//
// dbg_state_o exposes the FSM state: 0 IDLE, 1 BUSY, 2 DONE.
module miriscv_mdu_seq #(
   parameter int CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   miriscv_mdu_seq_if.slave  bus,
   output logic [CNT_W-1:0]  ops_cnt_o,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic [31:0]       a_q;
   logic [31:0]       b_q;
   logic [4:0]        rd_q;
   logic [31:0]       res_q;
   logic [CNT_W-1:0]  cnt_q;

   logic in_idle;
   logic in_busy;
   logic in_done;
   logic accept;
   logic complete;

   assign in_idle = (state == ST_IDLE);
   assign in_busy = (state == ST_BUSY);
   assign in_done = (state == ST_DONE);

   // Ready is also held low while reset is asserted so every output reads 0
   // during reset; a flush always blocks a new accept.
   assign bus.issue_ready_o = in_idle & ~bus.flush_i & arstn_i;
   assign accept            = bus.issue_valid_i & bus.issue_ready_o;

   // Flush wins over completion, so a flushed BUSY cycle never completes.
   assign complete = in_busy & ~bus.flush_i & ~bus.mdu_stall_req_i;

   assign bus.mdu_req_o    = in_busy & ~bus.flush_i;
   assign bus.mdu_kill_o   = in_busy & bus.flush_i;
   assign bus.mdu_op_o     = op_q;
   assign bus.mdu_port_a_o = a_q;
   assign bus.mdu_port_b_o = b_q;
   assign bus.wb_rd_o      = rd_q;

`ifdef MIRISCV_MDU_SEQ_BYPASS_EN
   // Completion cycle forwards the live MDU result; DONE replays the register.
   assign bus.wb_valid_o = (in_done & ~bus.flush_i) | complete;
   assign bus.wb_data_o  = complete ? bus.mdu_result_i : res_q;
`else
   // Result is only ever offered from the register, one cycle after completion.
   assign bus.wb_valid_o = in_done & ~bus.flush_i;
   assign bus.wb_data_o  = res_q;
`endif

   assign ops_cnt_o   = cnt_q;
   assign dbg_state_o = state;

   // FSM plus operand/result registers and the retired-operation counter.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state <= ST_IDLE;
         op_q  <= 3'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         rd_q  <= 5'd0;
         res_q <= 32'd0;
         cnt_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q  <= bus.issue_op_i;
                  a_q   <= bus.issue_a_i;
                  b_q   <= bus.issue_b_i;
                  rd_q  <= bus.issue_rd_i;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (bus.flush_i) begin
                  state <= ST_IDLE;
               end else if (!bus.mdu_stall_req_i) begin
                  res_q <= bus.mdu_result_i;
`ifdef MIRISCV_MDU_SEQ_BYPASS_EN
                  if (bus.wb_ready_i) begin
                     state <= ST_IDLE;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end else begin
                     state <= ST_DONE;
                  end
`else
                  state <= ST_DONE;
`endif
               end
            end
            ST_DONE: begin
               if (bus.flush_i) begin
                  state <= ST_IDLE;
               end else if (bus.wb_ready_i) begin
                  state <= ST_IDLE;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_miriscv_mdu_seq.sv
// tb_miriscv_mdu_seq: directed bench for miriscv_mdu_seq (CNT_W=4 so the
// counter wrap is reachable). Inputs change on the falling edge and outputs
// are checked 1 ns later; the DUT state advances on the rising edge.
// Build with or without MIRISCV_MDU_SEQ_BYPASS_EN; expectations follow it.
module tb_miriscv_mdu_seq;

   logic        clk = 1'b0;
   logic        arstn;
   logic [3:0]  ops_cnt;
   logic [1:0]  dbg_state;
   int          checks = 0;
   int          failures = 0;
   int          req_cycles;
   logic [3:0]  exp_cnt;
   logic [31:0] exp_data;
   logic [31:0] exp_q[$];

   miriscv_mdu_seq_if bus ();

   miriscv_mdu_seq #(.CNT_W(4)) dut (
      .clk_i       (clk),
      .arstn_i     (arstn),
      .bus         (bus),
      .ops_cnt_o   (ops_cnt),
      .dbg_state_o (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one operation on the issue port for the current cycle.
   task automatic drive_issue(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
      bus.issue_valid_i = 1'b1;
      bus.issue_op_i    = op;
      bus.issue_a_i     = a;
      bus.issue_b_i     = b;
      bus.issue_rd_i    = rd;
   endtask

   initial begin
      arstn               = 1'b0;
      bus.issue_valid_i   = 1'b0;
      bus.issue_op_i      = 3'd0;
      bus.issue_a_i       = 32'd0;
      bus.issue_b_i       = 32'd0;
      bus.issue_rd_i      = 5'd0;
      bus.flush_i         = 1'b0;
      bus.mdu_stall_req_i = 1'b0;
      bus.mdu_result_i    = 32'd0;
      bus.wb_ready_i      = 1'b0;

      // ---- reset state ----
      @(negedge clk); #1;
      chk("rst_ready", 32'(bus.issue_ready_o), 32'd0);
      chk("rst_req", 32'(bus.mdu_req_o), 32'd0);
      chk("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
      chk("rst_cnt", 32'(ops_cnt), 32'd0);
      @(negedge clk); arstn = 1'b1; #1;
      chk("post_rst_ready", 32'(bus.issue_ready_o), 32'd1);
      chk("post_rst_state", 32'(dbg_state), 32'd0);

      // ---- MULHU 0xFFFFFFFF*0xFFFFFFFF, 4 stall cycles, wb_ready=1 ----
      bus.wb_ready_i = 1'b1;
      @(negedge clk);
      drive_issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
      bus.mdu_stall_req_i = 1'b1;
      #1 chk("s1_accept_ready", 32'(bus.issue_ready_o), 32'd1);
      req_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.issue_valid_i   = 1'b0;
         bus.mdu_stall_req_i = (i < 4);
         bus.mdu_result_i    = (i == 4) ? 32'hFFFF_FFFE : 32'hDEAD_0000;
         #1;
         if (bus.mdu_req_o) req_cycles++;
         chk("s1_mdu_op", 32'(bus.mdu_op_o), 32'd3);
         chk("s1_port_a", bus.mdu_port_a_o, 32'hFFFF_FFFF);
`ifdef MIRISCV_MDU_SEQ_BYPASS_EN
         chk("s1_wb_valid_busy", 32'(bus.wb_valid_o), (i == 4) ? 32'd1 : 32'd0);
`else
         chk("s1_wb_valid_busy", 32'(bus.wb_valid_o), 32'd0);
`endif
      end
`ifdef MIRISCV_MDU_SEQ_BYPASS_EN
      chk("s1_wb_data", bus.wb_data_o, 32'hFFFF_FFFE);
      chk("s1_wb_rd", 32'(bus.wb_rd_o), 32'd5);
`else
      @(negedge clk); #1;
      chk("s1_wb_valid_done", 32'(bus.wb_valid_o), 32'd1);
      chk("s1_wb_data", bus.wb_data_o, 32'hFFFF_FFFE);
      chk("s1_wb_rd", 32'(bus.wb_rd_o), 32'd5);
      chk("s1_req_done", 32'(bus.mdu_req_o), 32'd0);
`endif
      @(negedge clk); #1;
      chk("s1_req_cycles", 32'(req_cycles), 32'd5);
      chk("s1_cnt", 32'(ops_cnt), 32'd1);
      chk("s1_idle_ready", 32'(bus.issue_ready_o), 32'd1);
      chk("s1_kill", 32'(bus.mdu_kill_o), 32'd0);

      // ---- DIVU 100/7, writeback held off 3 cycles ----
      bus.wb_ready_i = 1'b0;
      @(negedge clk);
      drive_issue(3'd5, 32'd100, 32'd7, 5'd9);
      bus.mdu_stall_req_i = 1'b1;
      @(negedge clk);
      bus.issue_valid_i   = 1'b0;
      bus.mdu_stall_req_i = 1'b0;
      bus.mdu_result_i    = 32'd14;
      #1 chk("s2_req", 32'(bus.mdu_req_o), 32'd1);
`ifdef MIRISCV_MDU_SEQ_BYPASS_EN
      chk("s2_wb_valid_cpl", 32'(bus.wb_valid_o), 32'd1);
      chk("s2_wb_data_cpl", bus.wb_data_o, 32'd14);
`else
      chk("s2_wb_valid_cpl", 32'(bus.wb_valid_o), 32'd0);
`endif
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.mdu_result_i    = 32'h5555_AAAA;
         bus.mdu_stall_req_i = 1'b1;
         #1;
         chk("s2_wb_valid_hold", 32'(bus.wb_valid_o), 32'd1);
         chk("s2_wb_data_hold", bus.wb_data_o, 32'd14);
         chk("s2_wb_rd_hold", 32'(bus.wb_rd_o), 32'd9);
         chk("s2_cnt_hold", 32'(ops_cnt), 32'd1);
      end
      @(negedge clk); bus.wb_ready_i = 1'b1; #1;
      chk("s2_wb_valid_rel", 32'(bus.wb_valid_o), 32'd1);
      chk("s2_no_accept_on_wb", 32'(bus.issue_ready_o), 32'd0);
      @(negedge clk); bus.wb_ready_i = 1'b0; #1;
      chk("s2_cnt_rel", 32'(ops_cnt), 32'd2);
      chk("s2_state_idle", 32'(dbg_state), 32'd0);
      @(negedge clk); #1;
      chk("s2_cnt_single", 32'(ops_cnt), 32'd2);

      // ---- DIV flushed in its 2nd BUSY cycle ----
      bus.wb_ready_i = 1'b1;
      @(negedge clk);
      drive_issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd3);
      bus.mdu_stall_req_i = 1'b1;
      @(negedge clk); bus.issue_valid_i = 1'b0; #1;
      chk("s3_req_b1", 32'(bus.mdu_req_o), 32'd1);
      chk("s3_kill_b1", 32'(bus.mdu_kill_o), 32'd0);
      @(negedge clk); bus.flush_i = 1'b1; #1;
      chk("s3_kill_b2", 32'(bus.mdu_kill_o), 32'd1);
      chk("s3_req_b2", 32'(bus.mdu_req_o), 32'd0);
      chk("s3_wb_valid_b2", 32'(bus.wb_valid_o), 32'd0);
      chk("s3_ready_flush", 32'(bus.issue_ready_o), 32'd0);
      @(negedge clk); bus.flush_i = 1'b0; #1;
      chk("s3_kill_after", 32'(bus.mdu_kill_o), 32'd0);
      chk("s3_ready_after", 32'(bus.issue_ready_o), 32'd1);
      chk("s3_wb_valid_after", 32'(bus.wb_valid_o), 32'd0);
      chk("s3_cnt", 32'(ops_cnt), 32'd2);

      // ---- REM 17%5 flushed while waiting in DONE ----
      bus.wb_ready_i = 1'b0;
      @(negedge clk);
      drive_issue(3'd6, 32'd17, 32'd5, 5'd4);
      bus.mdu_stall_req_i = 1'b0;
      @(negedge clk); bus.issue_valid_i = 1'b0; bus.mdu_result_i = 32'd2;
      @(negedge clk); bus.flush_i = 1'b1; #1;
      chk("sd_state_done", 32'(dbg_state), 32'd2);
      chk("sd_wb_valid_flush", 32'(bus.wb_valid_o), 32'd0);
      chk("sd_kill_flush", 32'(bus.mdu_kill_o), 32'd0);
      @(negedge clk); bus.flush_i = 1'b0; #1;
      chk("sd_state_idle", 32'(dbg_state), 32'd0);
      chk("sd_cnt", 32'(ops_cnt), 32'd2);

      // ---- MUL 3*5 with zero-cycle MDU completion ----
      bus.wb_ready_i = 1'b1;
      @(negedge clk);
      drive_issue(3'd0, 32'd3, 32'd5, 5'd7);
      @(negedge clk); bus.issue_valid_i = 1'b0; bus.mdu_result_i = 32'd15; #1;
`ifdef MIRISCV_MDU_SEQ_BYPASS_EN
      chk("s4_wb_valid_b1", 32'(bus.wb_valid_o), 32'd1);
      chk("s4_wb_data_b1", bus.wb_data_o, 32'd15);
      chk("s4_wb_rd_b1", 32'(bus.wb_rd_o), 32'd7);
`else
      chk("s4_wb_valid_b1", 32'(bus.wb_valid_o), 32'd0);
      @(negedge clk); #1;
      chk("s4_wb_valid_done", 32'(bus.wb_valid_o), 32'd1);
      chk("s4_wb_data_done", bus.wb_data_o, 32'd15);
`endif
      @(negedge clk); #1;
      chk("s4_state_idle", 32'(dbg_state), 32'd0);
      chk("s4_cnt", 32'(ops_cnt), 32'd3);

      // ---- 16 back-to-back MULs, counter wraps 15 -> 0 ----
      exp_cnt = 4'd3;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive_issue(3'd0, 32'(i), 32'd3, 5'(i + 1));
         bus.mdu_stall_req_i = 1'b0;
         #1;
         chk("s5_cnt", 32'(ops_cnt), 32'(exp_cnt));
         chk("s5_ready", 32'(bus.issue_ready_o), 32'd1);
         exp_q.push_back(32'(i * 3));
         @(negedge clk);
         bus.issue_valid_i = 1'b0;
         bus.mdu_result_i  = 32'(i * 3);
         #1;
`ifdef MIRISCV_MDU_SEQ_BYPASS_EN
         chk("s5_wb_valid", 32'(bus.wb_valid_o), 32'd1);
`else
         chk("s5_wb_valid_busy", 32'(bus.wb_valid_o), 32'd0);
         @(negedge clk); #1;
         chk("s5_wb_valid", 32'(bus.wb_valid_o), 32'd1);
         chk("s5_ready_on_wb", 32'(bus.issue_ready_o), 32'd0);
`endif
         exp_data = exp_q.pop_front();
         chk("s5_wb_data", bus.wb_data_o, exp_data);
         exp_cnt = exp_cnt + 4'd1;
      end
      @(negedge clk); #1;
      chk("s5_cnt_final", 32'(ops_cnt), 32'(exp_cnt));

      // ---- reset asserted during BUSY ----
      @(negedge clk);
      drive_issue(3'd1, 32'd7, 32'd9, 5'd11);
      bus.mdu_stall_req_i = 1'b1;
      @(negedge clk); bus.issue_valid_i = 1'b0; #1;
      chk("s6_req_before", 32'(bus.mdu_req_o), 32'd1);
      #2 arstn = 1'b0;
      #1;
      chk("s6_req", 32'(bus.mdu_req_o), 32'd0);
      chk("s6_kill", 32'(bus.mdu_kill_o), 32'd0);
      chk("s6_wb_valid", 32'(bus.wb_valid_o), 32'd0);
      chk("s6_ready", 32'(bus.issue_ready_o), 32'd0);
      chk("s6_cnt", 32'(ops_cnt), 32'd0);
      chk("s6_port_a", bus.mdu_port_a_o, 32'd0);
      chk("s6_port_b", bus.mdu_port_b_o, 32'd0);
      chk("s6_op", 32'(bus.mdu_op_o), 32'd0);
      chk("s6_wb_data", bus.wb_data_o, 32'd0);
      chk("s6_wb_rd", 32'(bus.wb_rd_o), 32'd0);
      @(negedge clk); #1;
      chk("s6_kill_in_rst", 32'(bus.mdu_kill_o), 32'd0);
      chk("s6_wb_valid_in_rst", 32'(bus.wb_valid_o), 32'd0);
      @(negedge clk); arstn = 1'b1; bus.mdu_stall_req_i = 1'b0; #1;
      chk("s6_ready_rel", 32'(bus.issue_ready_o), 32'd1);
      chk("s6_state_rel", 32'(dbg_state), 32'd0);
      @(negedge clk);
      drive_issue(3'd0, 32'd2, 32'd3, 5'd12);
      @(negedge clk); bus.issue_valid_i = 1'b0; bus.mdu_result_i = 32'd6; #1;
      chk("s6_req_new", 32'(bus.mdu_req_o), 32'd1);
`ifndef MIRISCV_MDU_SEQ_BYPASS_EN
      @(negedge clk); #1;
`endif
      chk("s6_wb_valid_new", 32'(bus.wb_valid_o), 32'd1);
      chk("s6_wb_data_new", bus.wb_data_o, 32'd6);
      chk("s6_wb_rd_new", 32'(bus.wb_rd_o), 32'd12);
      @(negedge clk); #1;
      chk("s6_cnt_new", 32'(ops_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
